// File: rtl/dbp_pkg.sv
// Shared types for the dynamic branch predictor.
// 2-bit saturating counter encoding and its next-state helper.
package dbp_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } cnt2_t;

  function automatic cnt2_t sat_next(
    input cnt2_t c,
    input logic  taken
  );
    cnt2_t n;
    n = c;
    unique case (1'b1)
      (taken && (c != STRONG_T)):
        n = cnt2_t'(c + 2'b01);
      (!taken && (c != STRONG_NT)):
        n = cnt2_t'(c - 2'b01);
      default:
        n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dbp_table.sv
// Flat storage array: whole contents exposed for combinational read,
// one synchronous write port, synchronous clear.
module dbp_table #(
  parameter int DEPTH_W = 4,
  parameter int W       = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_en,
  input  logic [DEPTH_W-1:0]                 wr_idx,
  input  logic [W-1:0]                       wr_data,
  output logic [(2**DEPTH_W)-1:0][W-1:0]     q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (wr_en) begin
      q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/dyn_branch_predictor.sv
// Bimodal BHT + direct-mapped BTB predictor with statistics.
// Define DBP_GSHARE_EN to XOR a global history register into the BHT index.
module dyn_branch_predictor
  import dbp_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [PC_W-1:0]  PC_curr,
  output logic [1:0]       prediction,
  output logic [PC_W-1:0]  predicted_target,
  output logic             btb_hit,
  output logic [IDX_W-1:0] lookup_idx,
  input  logic             update_valid,
  input  logic [IDX_W-1:0] update_idx,
  input  logic [TAG_W-1:0] update_tag,
  input  logic             update_taken,
  input  logic [PC_W-1:0]  update_target,
  input  logic             update_pred_taken,
  output logic [CNT_W-1:0] lookup_count,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int BTB_W = 1 + TAG_W + PC_W;
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] ONE = 1;

  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic [IDX_W-1:0] bht_idx;
  logic [IDX_W-1:0] btb_wr_idx;
  logic [DEPTH-1:0][1:0]       bht_q;
  logic [DEPTH-1:0][BTB_W-1:0] btb_q;
  logic [BTB_W-1:0] btb_rd;
  logic [1:0]       bht_wr;
  logic             unused_pc;

  assign pc_idx    = PC_curr[IDX_W:1];
  assign pc_tag    = PC_curr[IDX_W+TAG_W:IDX_W+1];
  assign unused_pc = ^PC_curr;

`ifdef DBP_GSHARE_EN
  logic [IDX_W-1:0] ghr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
    end else if (update_valid) begin
      ghr <= {ghr[IDX_W-2:0], update_taken};
    end
  end

  // BTB stays PC-indexed; undo the history hash on the returned index
  assign bht_idx    = pc_idx ^ ghr;
  assign btb_wr_idx = update_idx ^ ghr;
`else
  assign bht_idx    = pc_idx;
  assign btb_wr_idx = update_idx;
`endif

  assign bht_wr = sat_next(cnt2_t'(bht_q[update_idx]), update_taken);

  dbp_table #(.DEPTH_W(IDX_W), .W(2)) u_bht (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (update_valid),
    .wr_idx  (update_idx),
    .wr_data (bht_wr),
    .q       (bht_q)
  );

  dbp_table #(.DEPTH_W(IDX_W), .W(BTB_W)) u_btb (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (update_valid && update_taken),
    .wr_idx  (btb_wr_idx),
    .wr_data ({1'b1, update_tag, update_target}),
    .q       (btb_q)
  );

  assign btb_rd     = btb_q[pc_idx];
  assign btb_hit    = btb_rd[BTB_W-1] &&
                      (btb_rd[PC_W +: TAG_W] == pc_tag);
  assign predicted_target = btb_hit ? btb_rd[PC_W-1:0] : '0;
  assign prediction = bht_q[bht_idx];
  assign lookup_idx = bht_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      lookup_count     <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (enable && (lookup_count != '1))
        lookup_count <= lookup_count + ONE;
      if (update_valid && (branch_count != '1))
        branch_count <= branch_count + ONE;
      if (update_valid && (update_pred_taken != update_taken) &&
          (mispredict_count != '1))
        mispredict_count <= mispredict_count + ONE;
    end
  end

endmodule

// File: doc/dyn_branch_predictor.md
DYN_BRANCH_PREDICTOR -- requirements
Module: dyn_branch_predictor

Interface
REQ-001 Parameter PC_W, default 16: PC and target width in bits.
REQ-002 Parameter IDX_W, default 4: table index width; BHT and BTB depth = 2**IDX_W.
REQ-003 Parameter TAG_W, default 4: BTB tag width; legal only when IDX_W+TAG_W+1 <= PC_W.
REQ-004 Parameter CNT_W, default 16: width of each statistics counter.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 enable  in  1  lookup enable; 0 = fetch stalled, no lookup counted.
REQ-008 PC_curr  in  PC_W  fetch PC being predicted.
REQ-009 prediction  out  2  counter value read for the lookup; bit 1 = predict taken.
REQ-010 predicted_target  out  PC_W  BTB target; 0 on BTB miss.
REQ-011 btb_hit  out  1  BTB entry valid and tag matches.
REQ-012 lookup_idx  out  IDX_W  table index used for this lookup; pipelined by the decode stage and returned on update.
REQ-013 update_valid  in  1  resolved branch update this cycle.
REQ-014 update_idx  in  IDX_W  index returned from the lookup.
REQ-015 update_tag  in  TAG_W  tag bits of the resolved branch PC.
REQ-016 update_taken  in  1  actual branch direction.
REQ-017 update_target  in  PC_W  actual branch target.
REQ-018 update_pred_taken  in  1  prediction[1] carried from fetch.
REQ-019 lookup_count, branch_count, mispredict_count  out  CNT_W each  statistics counters.

Function
REQ-020 Lookup is combinational, same cycle: index = PC_curr[IDX_W:1] (bit 0 ignored); tag = PC_curr[IDX_W+TAG_W:IDX_W+1].
REQ-021 btb_hit = valid[idx] & (tag_mem[idx] == tag); predicted_target = btb_hit ? target_mem[idx] : 0.
REQ-022 On update_valid, BHT[update_idx] saturating-updates: +1 if taken, -1 if not; holds at 2'b11 and 2'b00.
REQ-023 On update_valid & update_taken, BTB[update_idx] <= {valid=1, update_tag, update_target}; not-taken updates leave the BTB unchanged.
REQ-024 Same-index read and write in one cycle: lookup returns the pre-write value; the new value is visible next cycle.
REQ-025 Updates apply regardless of enable; a stall never drops an update.
REQ-026 lookup_count +1 per cycle with enable=1; branch_count +1 per update_valid; mispredict_count +1 when update_valid & (update_pred_taken != update_taken).
REQ-027 All statistics counters saturate at all-ones and never wrap.

Reset
REQ-028 With rst=1 at a clock edge: every BHT entry <= 2'b00 (strongly not taken), every BTB valid <= 0, all statistics counters <= 0, GHR (if present) <= 0.
REQ-029 rst overrides a simultaneous update_valid; the update is discarded.
REQ-030 In the cycle after reset: prediction=2'b00, btb_hit=0, predicted_target=0.

Configuration
REQ-031 Macro DBP_GSHARE_EN: when defined, an IDX_W-bit global history register (GHR) is instantiated; BHT index = PC_curr[IDX_W:1] XOR GHR; on each update_valid, GHR <= {GHR[IDX_W-2:0], update_taken}.
REQ-032 BTB index stays PC-based under DBP_GSHARE_EN; lookup_idx reports the BHT index and the BTB write uses the PC index recomputed as update_idx XOR the GHR value in that cycle.
REQ-033 Without DBP_GSHARE_EN, no GHR exists and behaviour is exactly REQ-020..030.

Structure
REQ-034 A shared package dbp_pkg holds the 2-bit counter typedef (STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11) and the saturating next-state function.
REQ-035 A single sub-module dbp_table (parametrised depth/width, combinational read, synchronous write, synchronous clear) implements both BHT and BTB storage.

Verification
REQ-036 Reset, then lookup PC=0x0004 -> prediction=00, btb_hit=0, predicted_target=0x0000.
REQ-037 Three taken updates idx=2 with target 0x0040 -> BHT[2] steps 00->01->10->11; a fourth stays 11; lookup PC=0x0004 gives prediction=11, btb_hit=1, target=0x0040.
REQ-038 Update and lookup to idx=2 in the same cycle -> lookup shows the old value; the next cycle shows the new value.
REQ-039 Alias PC=0x0024 (same idx, tag differs) after REQ-037 -> btb_hit=0, target=0, prediction=11.
REQ-040 Drive 0xFFFF mispredicting updates with CNT_W=16 -> mispredict_count=0xFFFF; one more -> still 0xFFFF.
REQ-041 DBP_GSHARE_EN defined, updates taken,taken,not-taken from reset -> GHR=4'b0110; lookup PC=0x0002 uses BHT idx 0x7.
